// File: rtl/iccm_boot_arb_if.sv
// Programmer / bus-requester / ICCM signal bundle for iccm_boot_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface iccm_boot_arb_if;
  logic        prog_we_i;
  logic [11:0] prog_addr_i;
  logic [31:0] prog_wdata_i;
  logic        prog_done_i;

  logic        bus_req_i;
  logic        bus_we_i;
  logic [11:0] bus_addr_i;
  logic [31:0] bus_wdata_i;
  logic [3:0]  bus_be_i;
  logic        bus_gnt_o;
  logic        bus_rvalid_o;
  logic [31:0] bus_rdata_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  logic        core_rst_no;
  logic [12:0] load_words_o;

  modport slave (
    input  prog_we_i, prog_addr_i, prog_wdata_i, prog_done_i,
    input  bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_be_i,
    output bus_gnt_o, bus_rvalid_o, bus_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_rdata_i,
    output core_rst_no, load_words_o
  );

  modport master (
    output prog_we_i, prog_addr_i, prog_wdata_i, prog_done_i,
    output bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_be_i,
    input  bus_gnt_o, bus_rvalid_o, bus_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_rdata_i,
    input  core_rst_no, load_words_o
  );
endinterface

// File: rtl/iccm_boot_arb.sv
// ICCM boot arbiter: programmer download (LOAD/RELEASE) then bus access (RUN); mem_* is combinational, rvalid one cycle after grant.
// Programmer always wins; an ungranted bus request simply stays pending. Word counter enabled by ICCM_BOOT_ARB_WCNT_EN.
module iccm_boot_arb #(
  parameter bit          BOOT_HOLD   = 1'b1,
  parameter int unsigned RELEASE_CYC = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  iccm_boot_arb_if.slave  io
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam state_t     RST_STATE = BOOT_HOLD ? ST_LOAD : ST_RUN;
  localparam logic [3:0] REL_LAST  = 4'(RELEASE_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  rel_cnt_q, rel_cnt_d;
  logic        first_q;
  logic        rvalid_q;
  logic        rd_q;

  logic        prog_wr;
  logic        bus_gnt;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  // Nothing reaches the ICCM while reset is held, so its contents survive a reset.
  assign prog_wr = rst_ni & io.prog_we_i;
  assign bus_gnt = rst_ni & ~first_q & (state_q == ST_RUN) & ~io.prog_we_i & io.bus_req_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= RST_STATE;
      rel_cnt_q <= '0;
      first_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
      first_q   <= 1'b0;
      rvalid_q  <= bus_gnt;
      rd_q      <= bus_gnt & ~io.bus_we_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    unique case (state_q)
      ST_LOAD: begin
        if (io.prog_done_i) begin
          state_d   = ST_RELEASE;
          rel_cnt_d = '0;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_q == REL_LAST) begin
          state_d   = ST_RUN;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        // A programmer write while running starts a fresh download.
        if (io.prog_we_i) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d   = RST_STATE;
        rel_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (prog_wr) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = io.prog_addr_i;
      mem_wdata = io.prog_wdata_i;
      mem_be    = 4'hF;
    end else if (bus_gnt) begin
      mem_req   = 1'b1;
      mem_we    = io.bus_we_i;
      mem_addr  = io.bus_addr_i;
      mem_wdata = io.bus_wdata_i;
      mem_be    = io.bus_be_i;
    end
  end

  assign io.mem_req_o    = mem_req;
  assign io.mem_we_o     = mem_we;
  assign io.mem_addr_o   = mem_addr;
  assign io.mem_wdata_o  = mem_wdata;
  assign io.mem_be_o     = mem_be;

  assign io.bus_gnt_o    = bus_gnt;
  // Gating with rst_ni drops a response that was in flight when reset hit.
  assign io.bus_rvalid_o = rst_ni & rvalid_q;
  assign io.bus_rdata_o  = (rst_ni & rvalid_q & rd_q) ? io.mem_rdata_i : 32'h0;
  assign io.core_rst_no  = rst_ni & (state_q == ST_RUN);

`ifdef ICCM_BOOT_ARB_WCNT_EN
  logic [12:0] words_q;

  // The write that kicks RUN back to LOAD is the first word of the new download.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      words_q <= '0;
    end else if (prog_wr) begin
      if (state_q == ST_RUN) begin
        words_q <= 13'd1;
      end else if (words_q != 13'd4096) begin
        words_q <= words_q + 13'd1;
      end
    end
  end

  assign io.load_words_o = words_q;
`else
  assign io.load_words_o = '0;
`endif

endmodule

// File: tb/tb_iccm_boot_arb.sv
// Directed plus random bench for iccm_boot_arb against a cycle-level reference model.
module tb_iccm_boot_arb;
  localparam int REL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iccm_boot_arb_if bi ();
  iccm_boot_arb_if b0 ();

  iccm_boot_arb #(.BOOT_HOLD(1'b1), .RELEASE_CYC(REL)) dut (
    .clk_i (clk), .rst_ni(rst_n), .io(bi.slave));
  iccm_boot_arb #(.BOOT_HOLD(1'b0), .RELEASE_CYC(REL)) dut0 (
    .clk_i (clk), .rst_ni(rst_n), .io(b0.slave));

  assign b0.prog_we_i    = bi.prog_we_i;
  assign b0.prog_addr_i  = bi.prog_addr_i;
  assign b0.prog_wdata_i = bi.prog_wdata_i;
  assign b0.prog_done_i  = bi.prog_done_i;
  assign b0.bus_req_i    = bi.bus_req_i;
  assign b0.bus_we_i     = bi.bus_we_i;
  assign b0.bus_addr_i   = bi.bus_addr_i;
  assign b0.bus_wdata_i  = bi.bus_wdata_i;
  assign b0.bus_be_i     = bi.bus_be_i;
  assign b0.mem_rdata_i  = 32'h0;

  // Single-port ICCM behind the arbiter.
  logic [31:0] env_mem [4096];
  logic [31:0] env_rdata;
  bit          env_clr = 1'b1;
  assign bi.mem_rdata_i = env_rdata;

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 4096; i++) env_mem[i] <= 32'h0;
      env_rdata <= 32'h0;
    end else if (bi.mem_req_o) begin
      if (bi.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bi.mem_be_o[b]) env_mem[bi.mem_addr_o][8*b +: 8] <= bi.mem_wdata_o[8*b +: 8];
      end else begin
        env_rdata <= env_mem[bi.mem_addr_o];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: what the memory should hold and where the boot sequence is.
  logic [31:0] ref_mem [4096];
  bit          m_hold;
  int          m_rel_left;
  bit          m_first;
  bit          m_pend_rv;
  logic [31:0] m_pend_data;
  int          m_words;
  int          b0_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_running();
    return !m_hold && (m_rel_left == 0);
  endfunction

  task automatic step(input bit rst, input bit pwe, input logic [11:0] pa, input logic [31:0] pd,
                      input bit done, input bit breq, input bit bwe, input logic [11:0] ba,
                      input logic [31:0] bd, input logic [3:0] bbe);
    bit run, e_gnt, e_rv, e_req, e_we;
    logic [31:0] e_rd, e_wd;
    logic [11:0] e_ad;
    logic [3:0]  e_be;
    @(negedge clk);
    rst_n           = rst;
    bi.prog_we_i    = pwe;
    bi.prog_addr_i  = pa;
    bi.prog_wdata_i = pd;
    bi.prog_done_i  = done;
    bi.bus_req_i    = breq;
    bi.bus_we_i     = bwe;
    bi.bus_addr_i   = ba;
    bi.bus_wdata_i  = bd;
    bi.bus_be_i     = bbe;
    #1;
    run   = m_running();
    e_gnt = rst && !m_first && run && !pwe && breq;
    e_rv  = rst && m_pend_rv;
    e_rd  = e_rv ? m_pend_data : 32'h0;
    e_req = 1'b0; e_we = 1'b0; e_ad = '0; e_wd = '0; e_be = '0;
    if (rst && pwe) begin
      e_req = 1'b1; e_we = 1'b1; e_ad = pa; e_wd = pd; e_be = 4'hF;
    end else if (e_gnt) begin
      e_req = 1'b1; e_we = bwe; e_ad = ba; e_wd = bd; e_be = bbe;
    end
    check("core_rst_no", 32'(bi.core_rst_no), 32'(rst && run));
    check("bus_gnt", 32'(bi.bus_gnt_o), 32'(e_gnt));
    check("bus_rvalid", 32'(bi.bus_rvalid_o), 32'(e_rv));
    check("bus_rdata", bi.bus_rdata_o, e_rd);
    check("mem_req", 32'(bi.mem_req_o), 32'(e_req));
    check("mem_we", 32'(bi.mem_we_o), 32'(e_we));
    check("mem_addr", 32'(bi.mem_addr_o), 32'(e_ad));
    check("mem_wdata", bi.mem_wdata_o, e_wd);
    check("mem_be", 32'(bi.mem_be_o), 32'(e_be));
    check("load_words", 32'(bi.load_words_o), 32'(m_words));
    if (b0_mode == 1) begin
      check("b0_gnt_first", 32'(b0.bus_gnt_o), 32'h0);
      check("b0_core_run", 32'(b0.core_rst_no), 32'h1);
    end else if (b0_mode == 2) begin
      check("b0_gnt_second", 32'(b0.bus_gnt_o), 32'(breq));
    end
    @(posedge clk);
    if (!rst) begin
      m_hold = 1'b1 ? (dut.BOOT_HOLD == 1'b1) : 1'b0;
      m_rel_left = 0; m_words = 0; m_pend_rv = 1'b0; m_pend_data = '0; m_first = 1'b1;
    end else begin
      m_first     = 1'b0;
      m_pend_rv   = e_gnt;
      m_pend_data = (e_gnt && !bwe) ? ref_mem[ba] : 32'h0;
      if (pwe) ref_mem[pa] = pd;
      else if (e_gnt && bwe)
        for (int b = 0; b < 4; b++) if (bbe[b]) ref_mem[ba][8*b +: 8] = bd[8*b +: 8];
`ifdef ICCM_BOOT_ARB_WCNT_EN
      if (pwe) begin
        if (run) m_words = 1;
        else if (m_words < 4096) m_words++;
      end
`endif
      if (run && pwe) m_hold = 1'b1;
      else if (m_hold && done) begin
        m_hold = 1'b0;
        m_rel_left = REL;
      end else if (m_rel_left > 0) m_rel_left--;
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  task automatic go_run();
    int n = 0;
    if (m_hold) step(1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    while (!m_running() && n < 20) begin
      idle();
      n++;
    end
    #2;
    check("reach_run", 32'(bi.core_rst_no), 32'h1);
  endtask

  initial begin
    bit pwe, done, breq, bwe;
    int r;
    rst_n = 1'b0;
    bi.prog_we_i = 1'b0; bi.prog_addr_i = '0; bi.prog_wdata_i = '0; bi.prog_done_i = 1'b0;
    bi.bus_req_i = 1'b0; bi.bus_we_i = 1'b0; bi.bus_addr_i = '0; bi.bus_wdata_i = '0; bi.bus_be_i = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    m_hold = 1'b1; m_rel_left = 0; m_first = 1'b1; m_pend_rv = 1'b0; m_pend_data = '0; m_words = 0;

    // Reset: outputs quiet while held.
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 4'h0);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 4'h0);
    env_clr = 1'b0;

    // Boot download of three words, then release countdown.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 12'(i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    step(1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    for (int i = 0; i < REL; i++) begin
      #2;
      check("release_hold", 32'(bi.core_rst_no), 32'h0);
      idle();
    end
    #2;
    check("release_done", 32'(bi.core_rst_no), 32'h1);
`ifdef ICCM_BOOT_ARB_WCNT_EN
    check("boot_words", 32'(bi.load_words_o), 32'd3);
`else
    check("boot_words", 32'(bi.load_words_o), 32'd0);
`endif

    // Bus read of word 1.
    step(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 12'h001, 32'h0, 4'hF);
    #2;
    check("rd_a1_valid", 32'(bi.bus_rvalid_o), 32'h1);
    check("rd_a1_data", bi.bus_rdata_o, 32'h000000A1);
    idle();

    // Programmer write collides with a bus request in RUN.
    step(1'b1, 1'b1, 12'h010, 32'h5A5A_0010, 1'b0, 1'b1, 1'b0, 12'h002, 32'h0, 4'hF);
    #2;
    check("collide_core", 32'(bi.core_rst_no), 32'h0);
    check("collide_rvalid", 32'(bi.bus_rvalid_o), 32'h0);

    // Write and done in the same LOAD cycle.
    step(1'b1, 1'b1, 12'h011, 32'h5A5A_0011, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    go_run();

    // Random traffic across all states.
    for (int k = 0; k < 400; k++) begin
      r    = int'($urandom_range(0, 99));
      pwe  = (r < 6);
      done = (r >= 85);
      breq = 1'($urandom_range(0, 1));
      bwe  = 1'($urandom_range(0, 1));
      step(1'b1, pwe, 12'($urandom_range(0, 15)), $urandom, done, breq, bwe,
           12'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    end
    go_run();

    // Restart a download from RUN, then overflow the word counter.
    step(1'b1, 1'b1, 12'h000, 32'hA0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    for (int i = 0; i < 4097; i++)
      step(1'b1, 1'b1, 12'(i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    #2;
`ifdef ICCM_BOOT_ARB_WCNT_EN
    check("words_sat", 32'(bi.load_words_o), 32'd4096);
`else
    check("words_sat", 32'(bi.load_words_o), 32'd0);
`endif
    go_run();

    // Reset hits right after a read grant.
    step(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 12'h002, 32'h0, 4'hF);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    #2;
    check("rst_rvalid", 32'(bi.bus_rvalid_o), 32'h0);
    check("rst_rvalid_b0", 32'(b0.bus_rvalid_o), 32'h0);
    b0_mode = 1;
    step(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 12'h003, 32'h0, 4'hF);
    b0_mode = 2;
    step(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 12'h003, 32'h0, 4'hF);
    b0_mode = 0;
    #2;
    check("post_rst_load", 32'(bi.core_rst_no), 32'h0);
    check("post_rst_run_b0", 32'(b0.core_rst_no), 32'h1);
    check("post_rst_rvalid", 32'(bi.bus_rvalid_o), 32'h0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
